lsu_hs: RTL and testbench
=========================

Name: lsu_hs

Overview:
- Parametrised successor to the core's single-cycle load/store path.
- Accepts one load/store at a time from the execute stage and runs it over a valid/ready memory port with variable latency.
- Splits accesses that cross an XLEN/8-byte boundary into two memory transactions and merges the results.
- Returns load results on a one-cycle writeback strobe to the register file, and exposes busy/busy_rd for core stall and hazard logic.

Parameters:
- XLEN, 32, data/address width; legal values 32 or 64.
- REG_IDX_W, 4, register index width (4 = RV32E, 5 = RV32I).
- SUPPORT_MISALIGNED, 1, 1 = split/merge misaligned accesses; 0 = raise a fault instead.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_is_store  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word, 3 double (XLEN=64 only).
- req_unsigned  in  1  zero-extend load result.
- req_base  in  XLEN  rs1 value.
- req_offset  in  12  signed immediate.
- req_wdata  in  XLEN  store data, right-aligned.
- req_rd  in  REG_IDX_W  load destination.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  XLEN  XLEN/8-aligned address.
- mem_we  out  1  write enable.
- mem_be  out  XLEN/8  byte enables.
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_rsp_valid  in  1  response; one per accepted request, stores included.
- mem_rdata  in  XLEN  read data, valid with mem_rsp_valid.
- wb_valid  out  1  one-cycle writeback strobe.
- wb_rd  out  REG_IDX_W  writeback register.
- wb_data  out  XLEN  extended load data.
- busy  out  1  state != IDLE.
- busy_rd  out  REG_IDX_W  rd of the in-flight load; 0 for stores and when idle.
- fault_valid  out  1  one-cycle misalign fault pulse.
- fault_addr  out  XLEN  faulting effective address.

Behaviour:
- Reset: asynchronous, active-high. Forces IDLE and drives every output to 0 except req_ready, which is 1 once in IDLE.
  - An in-flight memory transaction is abandoned. Any later mem_rsp_valid is ignored, since IDLE ignores responses.
- Effective address: ea = req_base + sign_extend(req_offset), modulo 2^XLEN (wraps).
  - Captured together with all req_* fields on acceptance: IDLE && req_valid.
- Crossing: (ea mod XLEN/8) + 2^size > XLEN/8.
  - Misaligned but non-crossing accesses (e.g. SH at 0x101) take a single transaction.
- SUPPORT_MISALIGNED=0: any ea not naturally aligned is accepted, then FAULT for one cycle.
  - fault_valid=1, fault_addr=ea; no memory access; no writeback; then IDLE.
- States: IDLE -> REQ0 -> WAIT0 -> (crossing ? REQ1 -> WAIT1) -> (load ? WB) -> IDLE.
  - REQn: mem_req_valid=1. mem_addr, mem_we, mem_be and mem_wdata are held stable until mem_req_ready; advance on handshake.
  - WAITn: advance on mem_rsp_valid, capturing mem_rdata. mem_rsp_valid outside WAITn is ignored.
  - WB: wb_valid=1 for exactly one cycle with wb_rd and wb_data. Suppressed (no pulse) when rd=0; the access is still performed.
  - Stores return from their final WAIT directly to IDLE.
- Lanes: first transaction at floor(ea, XLEN/8) with mem_be covering bytes from ea to the word end.
  - Second transaction at the next word (wraps at 2^XLEN) with the remaining low bytes.
  - mem_wdata is req_wdata shifted left by 8*(ea mod XLEN/8); upper bytes go to the second word's low lanes.
- Load merge: bytes are concatenated low-address-first, then sign- or zero-extended from 8·2^size bits.
- Latency with zero-wait memory (ready=1, rsp the cycle after handshake), counted from the acceptance edge:
  - aligned load: wb_valid in cycle 3;
  - crossing load: cycle 5;
  - aligned store: IDLE in cycle 3.
- req_ready is 0 from the acceptance edge until IDLE. No request queuing; one outstanding transaction maximum.
- busy_rd is held during REQ/WAIT/WB of loads, so the core can stall dependent instructions.

Test Plan:
- LW, base 0x100, off 4, rd 5; mem returns 0xDEADBEEF -> mem_addr 0x104, be 4'b1111, we 0; wb_valid in cycle 3, wb_rd 5, wb_data 0xDEADBEEF.
- LB/LBU at 0x103, rdata 0x80123456 -> be 4'b1000; wb_data 0xFFFFFF80 (signed) / 0x00000080 (unsigned).
- Crossing LW at 0x106; rdata 0x5678AAAA then 0xBBBB1234 -> txn 0x104 be 4'b1100, txn 0x108 be 4'b0011; wb_data 0x12345678 in cycle 5.
- Crossing SH at 0x107, wdata 0xABCD -> 0x104 be 4'b1000 with byte3=0xCD; 0x108 be 4'b0001 with byte0=0xAB; no wb_valid.
- mem_req_ready low for 3 cycles on a load to x0 -> mem outputs stable, req_ready=0, busy=1; access completes with no wb_valid.
- rst pulsed during WAIT0, then a stale rsp arrives -> outputs 0 immediately, rsp ignored, next LW is correct; with SUPPORT_MISALIGNED=0, LW at 0x102 -> fault_valid pulse, fault_addr 0x102, no mem_req_valid.

Source files
------------

// File: rtl/lsu_hs_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_hs_if
//  Purpose  : Bundles the load/store unit's request, memory-port, writeback,
//             status and fault signals into one interface.
//  Modports : slave  - the load/store unit itself
//             master - the surrounding core/memory environment
//  Ports    : req_*        execute-stage request (valid/ready)
//             mem_*        valid/ready memory port with variable-latency rsp
//             wb_*         one-cycle register-file writeback strobe
//             busy/busy_rd stall and hazard status
//             fault_*      one-cycle misalign fault pulse
//  Revision : 1.0  initial release
// ============================================================================
interface lsu_hs_if #(
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 4
);
  // execute-stage request
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_is_store;
  logic [1:0]           req_size;
  logic                 req_unsigned;
  logic [XLEN-1:0]      req_base;
  logic [11:0]          req_offset;
  logic [XLEN-1:0]      req_wdata;
  logic [REG_IDX_W-1:0] req_rd;
  // memory port
  logic                 mem_req_valid;
  logic                 mem_req_ready;
  logic [XLEN-1:0]      mem_addr;
  logic                 mem_we;
  logic [XLEN/8-1:0]    mem_be;
  logic [XLEN-1:0]      mem_wdata;
  logic                 mem_rsp_valid;
  logic [XLEN-1:0]      mem_rdata;
  // writeback, status, fault
  logic                 wb_valid;
  logic [REG_IDX_W-1:0] wb_rd;
  logic [XLEN-1:0]      wb_data;
  logic                 busy;
  logic [REG_IDX_W-1:0] busy_rd;
  logic                 fault_valid;
  logic [XLEN-1:0]      fault_addr;

  modport slave (
    input  req_valid, req_is_store, req_size, req_unsigned, req_base,
           req_offset, req_wdata, req_rd, mem_req_ready, mem_rsp_valid,
           mem_rdata,
    output req_ready, mem_req_valid, mem_addr, mem_we, mem_be, mem_wdata,
           wb_valid, wb_rd, wb_data, busy, busy_rd, fault_valid, fault_addr
  );

  modport master (
    output req_valid, req_is_store, req_size, req_unsigned, req_base,
           req_offset, req_wdata, req_rd, mem_req_ready, mem_rsp_valid,
           mem_rdata,
    input  req_ready, mem_req_valid, mem_addr, mem_we, mem_be, mem_wdata,
           wb_valid, wb_rd, wb_data, busy, busy_rd, fault_valid, fault_addr
  );
endinterface
`default_nettype wire

// File: rtl/lsu_hs.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_hs
//  Purpose  : Single-outstanding load/store unit. Computes the effective
//             address, drives a valid/ready memory port with variable
//             latency, splits word-boundary-crossing accesses into two
//             transactions and merges/extends load data for writeback.
//  Ports    : clk  - clock, all state on rising edge
//             rst  - asynchronous active-high reset
//             bus  - lsu_hs_if.slave (request, memory, writeback, status,
//                    fault signals)
//  Revision : 1.0  initial release
// ============================================================================
module lsu_hs #(
  parameter int XLEN               = 32,
  parameter int REG_IDX_W          = 4,
  parameter int SUPPORT_MISALIGNED = 1
) (
  input wire      clk,
  input wire      rst,
  lsu_hs_if.slave bus
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ0  = 3'd1,
    S_WAIT0 = 3'd2,
    S_REQ1  = 3'd3,
    S_WAIT1 = 3'd4,
    S_WB    = 3'd5,
    S_FAULT = 3'd6
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t               state_q,  state_d;
  logic [XLEN-1:0]      ea_q,     ea_d;
  logic [1:0]           size_q,   size_d;
  logic                 store_q,  store_d;
  logic                 uns_q,    uns_d;
  logic [REG_IDX_W-1:0] rd_q,     rd_d;
  logic                 cross_q,  cross_d;
  logic [2*NB-1:0]      be_q,     be_d;      // both transactions' enables
  logic [2*XLEN-1:0]    wdata_q,  wdata_d;   // both transactions' lanes
  logic [XLEN-1:0]      rdata0_q, rdata0_d;
  logic [XLEN-1:0]      rdata1_q, rdata1_d;

  // --------------------------------------------------------------------------
  // Request decode (only meaningful while IDLE)
  // --------------------------------------------------------------------------
  logic [XLEN-1:0]  ea;
  logic [1:0]       size_eff;
  logic [OFF_W-1:0] ea_off;
  logic [4:0]       span;
  logic             crossing;
  logic             take_fault;
  logic [2*NB-1:0]  be_base;
  logic [XLEN-1:0]  wmask;

  assign ea       = bus.req_base + XLEN'($signed(bus.req_offset));
  // A double request on a 32-bit core has no meaning; treat it as a word.
  assign size_eff = (XLEN == 32 && bus.req_size == 2'd3) ? 2'd2 : bus.req_size;
  assign ea_off   = ea[OFF_W-1:0];
  assign span     = 5'(ea_off) + (5'd1 << size_eff);
  assign crossing = (span > 5'(NB));

  if (SUPPORT_MISALIGNED != 0) begin : g_split
    assign take_fault = 1'b0;
  end else begin : g_fault
    logic [OFF_W-1:0] align_mask;
    assign align_mask = OFF_W'((5'd1 << size_eff) - 5'd1);
    assign take_fault = |(ea_off & align_mask);
  end

  always_comb begin
    be_base = '0;
    wmask   = '0;
    case (size_eff)
      2'd0:    begin be_base = (2*NB)'(8'h01); wmask = XLEN'(8'hFF);       end
      2'd1:    begin be_base = (2*NB)'(8'h03); wmask = XLEN'(16'hFFFF);    end
      2'd2:    begin be_base = (2*NB)'(8'h0F); wmask = XLEN'(32'hFFFFFFFF); end
      default: begin be_base = (2*NB)'(8'hFF); wmask = '1;                 end
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    ea_d     = ea_q;
    size_d   = size_q;
    store_d  = store_q;
    uns_d    = uns_q;
    rd_d     = rd_q;
    cross_d  = cross_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          ea_d     = ea;
          size_d   = size_eff;
          store_d  = bus.req_is_store;
          uns_d    = bus.req_unsigned;
          rd_d     = bus.req_rd;
          cross_d  = crossing;
          // Shift across a double-width window: the upper half becomes
          // the second transaction's low lanes.
          be_d     = be_base << ea_off;
          wdata_d  = ((2*XLEN)'(bus.req_wdata & wmask)) << {ea_off, 3'b000};
          rdata0_d = '0;
          rdata1_d = '0;
          state_d  = take_fault ? S_FAULT : S_REQ0;
        end
      end
      S_REQ0: begin
        if (bus.mem_req_ready) state_d = S_WAIT0;
      end
      S_WAIT0: begin
        if (bus.mem_rsp_valid) begin
          rdata0_d = bus.mem_rdata;
          if (cross_q)      state_d = S_REQ1;
          else if (store_q) state_d = S_IDLE;
          else              state_d = S_WB;
        end
      end
      S_REQ1: begin
        if (bus.mem_req_ready) state_d = S_WAIT1;
      end
      S_WAIT1: begin
        if (bus.mem_rsp_valid) begin
          rdata1_d = bus.mem_rdata;
          state_d  = store_q ? S_IDLE : S_WB;
        end
      end
      S_WB:    state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ea_q     <= '0;
      size_q   <= '0;
      store_q  <= 1'b0;
      uns_q    <= 1'b0;
      rd_q     <= '0;
      cross_q  <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      ea_q     <= ea_d;
      size_q   <= size_d;
      store_q  <= store_d;
      uns_q    <= uns_d;
      rd_q     <= rd_d;
      cross_q  <= cross_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // --------------------------------------------------------------------------
  // Load merge: low-address bytes come from the first word, so shifting the
  // concatenation right by the byte offset aligns the access to bit 0.
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] load_raw;
  logic [XLEN-1:0] load_ext;
  logic [XLEN-1:0] word0_addr;
  logic [XLEN-1:0] word1_addr;

  assign load_raw   = XLEN'({rdata1_q, rdata0_q} >> {ea_q[OFF_W-1:0], 3'b000});
  assign word0_addr = {ea_q[XLEN-1:OFF_W], {OFF_W{1'b0}}};
  assign word1_addr = word0_addr + XLEN'(NB);

  always_comb begin
    load_ext = load_raw;
    case (size_q)
      2'd0: load_ext = uns_q ? XLEN'(load_raw[7:0])  : XLEN'($signed(load_raw[7:0]));
      2'd1: load_ext = uns_q ? XLEN'(load_raw[15:0]) : XLEN'($signed(load_raw[15:0]));
      2'd2: load_ext = uns_q ? XLEN'(load_raw[31:0]) : XLEN'($signed(load_raw[31:0]));
      default: load_ext = load_raw;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs: everything is decoded from registered state so that outputs are
  // zero whenever the unit is idle or in reset.
  // --------------------------------------------------------------------------
  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.busy_rd   = (state_q != S_IDLE && state_q != S_FAULT && !store_q)
                         ? rd_q : '0;

  always_comb begin
    bus.mem_req_valid = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_we        = 1'b0;
    bus.mem_be        = '0;
    bus.mem_wdata     = '0;
    bus.wb_valid      = 1'b0;
    bus.wb_rd         = '0;
    bus.wb_data       = '0;
    bus.fault_valid   = 1'b0;
    bus.fault_addr    = '0;
    case (state_q)
      S_REQ0: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_addr      = word0_addr;
        bus.mem_we        = store_q;
        bus.mem_be        = be_q[NB-1:0];
        bus.mem_wdata     = wdata_q[XLEN-1:0];
      end
      S_REQ1: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_addr      = word1_addr;
        bus.mem_we        = store_q;
        bus.mem_be        = be_q[2*NB-1:NB];
        bus.mem_wdata     = wdata_q[2*XLEN-1:XLEN];
      end
      S_WB: begin
        // x0 is never written; the access itself has already happened.
        if (rd_q != '0) begin
          bus.wb_valid = 1'b1;
          bus.wb_rd    = rd_q;
          bus.wb_data  = load_ext;
        end
      end
      S_FAULT: begin
        bus.fault_valid = 1'b1;
        bus.fault_addr  = ea_q;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_hs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_hs
//  Purpose  : Directed self-checking bench for lsu_hs (XLEN=32, RV32E).
//             A second instance with misaligned support disabled covers the
//             fault path.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lsu_hs;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  lsu_hs_if #(.XLEN(32), .REG_IDX_W(4)) bus   ();
  lsu_hs_if #(.XLEN(32), .REG_IDX_W(4)) bus_f ();

  lsu_hs #(.XLEN(32), .REG_IDX_W(4), .SUPPORT_MISALIGNED(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  lsu_hs #(.XLEN(32), .REG_IDX_W(4), .SUPPORT_MISALIGNED(0)) dut_f (
    .clk (clk),
    .rst (rst),
    .bus (bus_f)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one cycle; returns in cycle 1 after acceptance.
  task automatic issue(input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] base, input logic [11:0] off,
                       input logic [31:0] wd, input logic [3:0] rd);
    chk("req_ready_before_issue", bus.req_ready, 1'b1);
    bus.req_valid    = 1'b1;
    bus.req_is_store = st;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_base     = base;
    bus.req_offset   = off;
    bus.req_wdata    = wd;
    bus.req_rd       = rd;
    tick;
    bus.req_valid    = 1'b0;
  endtask

  task automatic rsp(input logic [31:0] d);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = d;
    tick;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = '0;
  endtask

  initial begin
    bus.req_valid = 0; bus.req_is_store = 0; bus.req_size = 0; bus.req_unsigned = 0;
    bus.req_base = 0; bus.req_offset = 0; bus.req_wdata = 0; bus.req_rd = 0;
    bus.mem_req_ready = 1; bus.mem_rsp_valid = 0; bus.mem_rdata = 0;
    bus_f.req_valid = 0; bus_f.req_is_store = 0; bus_f.req_size = 0; bus_f.req_unsigned = 0;
    bus_f.req_base = 0; bus_f.req_offset = 0; bus_f.req_wdata = 0; bus_f.req_rd = 0;
    bus_f.mem_req_ready = 1; bus_f.mem_rsp_valid = 0; bus_f.mem_rdata = 0;

    // ---------------- reset state ----------------
    tick; tick;
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_mem_req_valid", bus.mem_req_valid, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_wb_valid", bus.wb_valid, 1'b0);
    chk("rst_fault_valid", bus.fault_valid, 1'b0);
    rst = 1'b0;
    tick;

    // ---------------- LW 0x100+4 -> rd5 ----------------
    issue(1'b0, 2'd2, 1'b0, 32'h100, 12'd4, 32'h0, 4'd5);
    chk("lw_req_valid", bus.mem_req_valid, 1'b1);
    chk("lw_addr", bus.mem_addr, 32'h104);
    chk("lw_be", bus.mem_be, 4'b1111);
    chk("lw_we", bus.mem_we, 1'b0);
    chk("lw_req_ready", bus.req_ready, 1'b0);
    chk("lw_busy_rd", bus.busy_rd, 4'd5);
    tick;                                    // cycle 2: WAIT0
    chk("lw_wait_no_req", bus.mem_req_valid, 1'b0);
    rsp(32'hDEADBEEF);                       // cycle 3: WB
    chk("lw_wb_valid_c3", bus.wb_valid, 1'b1);
    chk("lw_wb_rd", bus.wb_rd, 4'd5);
    chk("lw_wb_data", bus.wb_data, 32'hDEADBEEF);
    tick;
    chk("lw_wb_one_cycle", bus.wb_valid, 1'b0);
    chk("lw_idle_busy", bus.busy, 1'b0);

    // ---------------- LB / LBU at 0x103 ----------------
    issue(1'b0, 2'd0, 1'b0, 32'h100, 12'd3, 32'h0, 4'd6);
    chk("lb_addr", bus.mem_addr, 32'h100);
    chk("lb_be", bus.mem_be, 4'b1000);
    tick;
    rsp(32'h80123456);
    chk("lb_wb_data", bus.wb_data, 32'hFFFFFF80);
    tick;
    issue(1'b0, 2'd0, 1'b1, 32'h100, 12'd3, 32'h0, 4'd6);
    chk("lbu_be", bus.mem_be, 4'b1000);
    tick;
    rsp(32'h80123456);
    chk("lbu_wb_data", bus.wb_data, 32'h00000080);
    tick;

    // ---------------- crossing LW at 0x106 ----------------
    issue(1'b0, 2'd2, 1'b0, 32'h100, 12'd6, 32'h0, 4'd7);
    chk("xlw_addr0", bus.mem_addr, 32'h104);
    chk("xlw_be0", bus.mem_be, 4'b1100);
    tick;
    rsp(32'h5678AAAA);                       // cycle 3: REQ1
    chk("xlw_wb_not_c3", bus.wb_valid, 1'b0);
    chk("xlw_addr1", bus.mem_addr, 32'h108);
    chk("xlw_be1", bus.mem_be, 4'b0011);
    tick;                                    // cycle 4: WAIT1
    chk("xlw_wb_not_c4", bus.wb_valid, 1'b0);
    rsp(32'hBBBB1234);                       // cycle 5: WB
    chk("xlw_wb_valid_c5", bus.wb_valid, 1'b1);
    chk("xlw_wb_data", bus.wb_data, 32'h12345678);
    tick;

    // ---------------- crossing SH at 0x107 ----------------
    issue(1'b1, 2'd1, 1'b0, 32'h100, 12'd7, 32'h0000ABCD, 4'd0);
    chk("xsh_addr0", bus.mem_addr, 32'h104);
    chk("xsh_be0", bus.mem_be, 4'b1000);
    chk("xsh_we0", bus.mem_we, 1'b1);
    chk("xsh_wdata0", bus.mem_wdata, 32'hCD000000);
    chk("xsh_busy_rd", bus.busy_rd, 4'd0);
    tick;
    rsp(32'h0);
    chk("xsh_addr1", bus.mem_addr, 32'h108);
    chk("xsh_be1", bus.mem_be, 4'b0001);
    chk("xsh_wdata1", bus.mem_wdata, 32'h000000AB);
    tick;
    rsp(32'h0);
    chk("xsh_no_wb", bus.wb_valid, 1'b0);
    chk("xsh_idle", bus.req_ready, 1'b1);

    // ---------------- backpressure, load to x0 ----------------
    bus.mem_req_ready = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 32'h200, 12'd0, 32'h0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_req_valid", bus.mem_req_valid, 1'b1);
      chk("bp_addr_stable", bus.mem_addr, 32'h200);
      chk("bp_be_stable", bus.mem_be, 4'b1111);
      chk("bp_req_ready", bus.req_ready, 1'b0);
      chk("bp_busy", bus.busy, 1'b1);
      tick;
    end
    bus.mem_req_ready = 1'b1;
    chk("bp_still_valid", bus.mem_req_valid, 1'b1);
    tick;
    rsp(32'h11111111);
    chk("bp_x0_no_wb", bus.wb_valid, 1'b0);
    chk("bp_x0_busy_in_wb", bus.busy, 1'b1);
    tick;
    chk("bp_done_idle", bus.busy, 1'b0);

    // ---------------- reset during WAIT0, stale response ----------------
    issue(1'b0, 2'd2, 1'b0, 32'h300, 12'd0, 32'h0, 4'd3);
    tick;                                    // WAIT0
    rst = 1'b1;
    #1;
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_req_ready", bus.req_ready, 1'b1);
    chk("arst_busy_rd", bus.busy_rd, 4'd0);
    tick;
    rst = 1'b0;
    rsp(32'h0BAD0BAD);
    chk("stale_no_wb", bus.wb_valid, 1'b0);
    chk("stale_idle", bus.busy, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h100, 12'd8, 32'h0, 4'd9);
    chk("post_rst_addr", bus.mem_addr, 32'h108);
    tick;
    rsp(32'hCAFEF00D);
    chk("post_rst_wb_rd", bus.wb_rd, 4'd9);
    chk("post_rst_wb_data", bus.wb_data, 32'hCAFEF00D);
    tick;

    // ---------------- fault instance: LW at 0x102 ----------------
    chk("f_req_ready", bus_f.req_ready, 1'b1);
    bus_f.req_valid = 1'b1; bus_f.req_size = 2'd2; bus_f.req_base = 32'h100;
    bus_f.req_offset = 12'd2; bus_f.req_rd = 4'd6;
    tick;
    bus_f.req_valid = 1'b0;
    chk("f_fault_valid", bus_f.fault_valid, 1'b1);
    chk("f_fault_addr", bus_f.fault_addr, 32'h102);
    chk("f_no_mem_req", bus_f.mem_req_valid, 1'b0);
    tick;
    chk("f_fault_one_cycle", bus_f.fault_valid, 1'b0);
    chk("f_no_mem_req2", bus_f.mem_req_valid, 1'b0);
    chk("f_no_wb", bus_f.wb_valid, 1'b0);
    chk("f_back_idle", bus_f.req_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
